// File: rtl/dio_loader.sv
// Copies a finished SPI download from the data_io buffer into Apple II target memory.
// Latency: RD_LAT+2 clocks per byte plus target wait cycles; done pulses one clock after the last write.
// Backpressure: tgt_req/tgt_addr/tgt_data hold until tgt_ack; a new download aborts the copy.
module dio_loader #(
    parameter logic [15:0] DEST_BASE = 16'h0000,
    parameter logic [15:0] MAX_LEN   = 16'hC000,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        downloading,
    input  logic [15:0] size,
    output logic [15:0] ram_a,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic [15:0] tgt_addr,
    output logic [7:0]  tgt_data,
    output logic        tgt_req,
    input  logic        tgt_ack,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LATCH,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    state_t      state;
    logic        dl_m;
    logic        dl_s;
    logic        dl_q;
    logic        dl_rise;
    logic        dl_fall;
    logic [15:0] index;
    logic [15:0] len;
    logic [15:0] index_nxt;
    logic [15:0] len_new;
    logic [1:0]  rd_cnt;

    assign dl_rise   = dl_s & ~dl_q;
    assign dl_fall   = ~dl_s & dl_q;
    assign index_nxt = index + 16'd1;
    assign len_new   = (size > MAX_LEN) ? MAX_LEN : size;
    assign ram_we    = 1'b0;

    // downloading comes from the SPI clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_m <= 1'b0;
            dl_s <= 1'b0;
            dl_q <= 1'b0;
        end else begin
            dl_m <= downloading;
            dl_s <= dl_m;
            dl_q <= dl_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ram_a    <= 16'h0000;
            tgt_addr <= 16'h0000;
            tgt_data <= 8'h00;
            tgt_req  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            index    <= 16'h0000;
            len      <= 16'h0000;
            rd_cnt   <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dl_rise) begin
                        state <= S_ARM;
                        busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (dl_fall) begin
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (dl_rise) begin
                        state <= S_ARM;
                    end else begin
                        len    <= len_new;
                        index  <= 16'h0000;
                        ram_a  <= 16'h0000;
                        rd_cnt <= 2'd0;
                        if (len_new == 16'h0000) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (dl_rise) begin
                        state <= S_ARM;
                    end else begin
                        ram_a <= index;
                        if (rd_cnt == RD_LAST) begin
                            state <= S_CAP;
                        end else begin
                            rd_cnt <= rd_cnt + 2'd1;
                        end
                    end
                end
                S_CAP: begin
                    // ram_dout is valid in this cycle for the address issued on RD entry
                    if (dl_rise) begin
                        state <= S_ARM;
                    end else begin
                        tgt_data <= ram_dout;
                        tgt_addr <= DEST_BASE + index;
                        tgt_req  <= 1'b1;
                        state    <= S_WR;
                    end
                end
                S_WR: begin
                    if (dl_rise) begin
                        tgt_req <= 1'b0;
                        state   <= S_ARM;
                    end else if (tgt_ack) begin
                        tgt_req <= 1'b0;
                        index   <= index_nxt;
                        if (index_nxt == len) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state  <= S_RD;
                            ram_a  <= index_nxt;
                            rd_cnt <= 2'd0;
                        end
                    end
                end
                S_DONE: begin
                    if (dl_rise) begin
                        state <= S_ARM;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dio_loader.sv
// Bench for dio_loader: two instances (different base, clamp and read latency) share one download.
module tb_dio_loader;

    localparam logic [15:0] BASE0 = 16'h0800;
    localparam logic [15:0] BASE1 = 16'hFFFE;
    localparam logic [15:0] MAXL0 = 16'hC000;
    localparam logic [15:0] MAXL1 = 16'h0020;

    logic             clk = 1'b0;
    logic             reset;
    logic             downloading;
    logic [15:0]      size;
    logic [1:0][15:0] ram_a;
    logic [1:0]       ram_we;
    logic [1:0][7:0]  ram_dout;
    logic [1:0][15:0] tgt_addr;
    logic [1:0][7:0]  tgt_data;
    logic [1:0]       tgt_req;
    logic [1:0]       tgt_ack = 2'b00;
    logic [1:0]       busy;
    logic [1:0]       done;

    always #5 clk = ~clk;

    dio_loader #(.DEST_BASE(BASE0), .MAX_LEN(MAXL0), .RD_LAT(1)) u0 (
        .clk(clk), .reset(reset), .downloading(downloading), .size(size),
        .ram_a(ram_a[0]), .ram_we(ram_we[0]), .ram_dout(ram_dout[0]),
        .tgt_addr(tgt_addr[0]), .tgt_data(tgt_data[0]), .tgt_req(tgt_req[0]),
        .tgt_ack(tgt_ack[0]), .busy(busy[0]), .done(done[0])
    );

    dio_loader #(.DEST_BASE(BASE1), .MAX_LEN(MAXL1), .RD_LAT(2)) u1 (
        .clk(clk), .reset(reset), .downloading(downloading), .size(size),
        .ram_a(ram_a[1]), .ram_we(ram_we[1]), .ram_dout(ram_dout[1]),
        .tgt_addr(tgt_addr[1]), .tgt_data(tgt_data[1]), .tgt_req(tgt_req[1]),
        .tgt_ack(tgt_ack[1]), .busy(busy[1]), .done(done[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // download buffer: u0 sees one clock of read latency, u1 two
    logic [7:0] mem [256];
    logic [7:0] pipe1;
    always @(posedge clk) begin
        ram_dout[0] <= mem[ram_a[0][7:0]];
        pipe1       <= mem[ram_a[1][7:0]];
        ram_dout[1] <= pipe1;
    end

    // target side: ack policy controlled by the running test
    int ack_pct      = 100;
    int ack_limit[2] = '{32'h7fffffff, 32'h7fffffff};
    int stall_at[2]  = '{-1, -1};
    int stall_len    = 0;
    int stall_done[2] = '{0, 0};

    int          wcnt[2]     = '{0, 0};
    logic [23:0] wlog[2][2048];
    int          done_cnt[2] = '{0, 0};
    int          req_cyc[2]  = '{0, 0};
    int          we_seen[2]  = '{0, 0};
    int          st_n[2]     = '{0, 0};
    logic [23:0] st_log[2][64];

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (wcnt[k] != stall_at[k]) stall_done[k] = 0;
            if (wcnt[k] >= ack_limit[k]) begin
                tgt_ack[k] = 1'b0;
            end else if (tgt_req[k] && wcnt[k] == stall_at[k] && stall_done[k] < stall_len) begin
                tgt_ack[k] = 1'b0;
                stall_done[k]++;
            end else begin
                tgt_ack[k] = ($urandom_range(99) < ack_pct);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tgt_req[k] && !tgt_ack[k] && wcnt[k] == stall_at[k]) begin
                st_log[k][st_n[k] % 64] = {tgt_addr[k], tgt_data[k]};
                st_n[k]++;
            end
            if (tgt_req[k] && tgt_ack[k]) begin
                wlog[k][wcnt[k] % 2048] = {tgt_addr[k], tgt_data[k]};
                wcnt[k]++;
            end
            if (done[k]) done_cnt[k]++;
            if (tgt_req[k]) req_cyc[k]++;
            if (ram_we[k]) we_seen[k]++;
        end
    end

    function automatic int exp_len(input int k, input logic [15:0] sz);
        logic [15:0] m;
        m = (k == 0) ? MAXL0 : MAXL1;
        return (sz > m) ? int'(m) : int'(sz);
    endfunction

    function automatic logic [15:0] base_of(input int k);
        return (k == 0) ? BASE0 : BASE1;
    endfunction

    // full download + copy, checked against the expected byte stream
    task automatic test_copy(input string name, input logic [15:0] sz, input int pct, input bit fixed);
        int b[2];
        int d[2];
        int w[2];
        int n;
        int t;
        logic [15:0] ea;
        logic [23:0] got;
        if (!fixed) for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        ack_pct = pct;
        for (int k = 0; k < 2; k++) begin
            b[k] = wcnt[k];
            d[k] = done_cnt[k];
            w[k] = we_seen[k];
        end
        @(negedge clk) downloading = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (busy !== 2'b11) begin
            n_bad++;
            $display("FAIL %s busy_during_download: got %b expected 11", name, busy);
        end
        size = sz;
        downloading = 1'b0;
        t = 0;
        while (!(done_cnt[0] > d[0] && done_cnt[1] > d[1]) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 5000) begin
            n_bad++;
            $display("FAIL %s done_timeout: waited %0d cycles, required done from both", name, t);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n = exp_len(k, sz);
            n_cmp++;
            if (wcnt[k] - b[k] != n) begin
                n_bad++;
                $display("FAIL %s u%0d write_count: got %0d expected %0d", name, k, wcnt[k] - b[k], n);
            end
            for (int i = 0; i < n && i < wcnt[k] - b[k]; i++) begin
                ea = base_of(k) + 16'(i);
                got = wlog[k][(b[k] + i) % 2048];
                n_cmp++;
                if (got !== {ea, mem[i]}) begin
                    n_bad++;
                    $display("FAIL %s u%0d write%0d: got %h:%h expected %h:%h",
                             name, k, i, got[23:8], got[7:0], ea, mem[i]);
                end
            end
            n_cmp++;
            if (done_cnt[k] - d[k] != 1) begin
                n_bad++;
                $display("FAIL %s u%0d done_cycles: got %0d expected 1", name, k, done_cnt[k] - d[k]);
            end
            n_cmp++;
            if (busy[k] !== 1'b0 || we_seen[k] != w[k]) begin
                n_bad++;
                $display("FAIL %s u%0d busy/ram_we after copy: busy=%b we_cycles=%0d expected 0/0",
                         name, k, busy[k], we_seen[k] - w[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        downloading = 1'b0;
        size = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #12;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({ram_a[k], ram_we[k], tgt_addr[k], tgt_data[k], tgt_req[k], busy[k], done[k]} !== 43'd0) begin
                n_bad++;
                $display("FAIL reset u%0d outputs: got a=%h we=%b ta=%h td=%h req=%b busy=%b done=%b expected all 0",
                         k, ram_a[k], ram_we[k], tgt_addr[k], tgt_data[k], tgt_req[k], busy[k], done[k]);
            end
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
        test_copy("basic4", 16'd4, 100, 1'b1);
    endtask

    task automatic test_stall();
        int s[2];
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
        stall_len = 5;
        for (int k = 0; k < 2; k++) begin
            s[k] = st_n[k];
            stall_at[k] = wcnt[k] + 1;
        end
        test_copy("stall", 16'd4, 100, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (st_n[k] - s[k] != 5) begin
                n_bad++;
                $display("FAIL stall u%0d held_cycles: got %0d expected 5", k, st_n[k] - s[k]);
            end
            for (int i = s[k]; i < st_n[k] && i < s[k] + 5; i++) begin
                n_cmp++;
                if (st_log[k][i % 64] !== {base_of(k) + 16'd1, 8'hBB}) begin
                    n_bad++;
                    $display("FAIL stall u%0d held%0d: got %h expected %h%h",
                             k, i - s[k], st_log[k][i % 64], base_of(k) + 16'd1, 8'hBB);
                end
            end
            stall_at[k] = -1;
        end
        stall_len = 0;
    endtask

    task automatic test_zero();
        int r[2];
        int d[2];
        for (int k = 0; k < 2; k++) begin
            r[k] = req_cyc[k];
            d[k] = done_cnt[k];
        end
        @(negedge clk) downloading = 1'b1;
        repeat (6) @(negedge clk);
        size = 16'd0;
        downloading = 1'b0;
        // two sync flops, edge detect, LATCH, then the DONE cycle
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== ((j == 4) ? 2'b11 : 2'b00)) begin
                n_bad++;
                $display("FAIL zero done_at_clock%0d: got %b expected %b", j, done, (j == 4) ? 2'b11 : 2'b00);
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (req_cyc[k] != r[k] || busy[k] !== 1'b0 || done_cnt[k] - d[k] != 1) begin
                n_bad++;
                $display("FAIL zero u%0d: req_cycles=%0d busy=%b dones=%0d expected 0/0/1",
                         k, req_cyc[k] - r[k], busy[k], done_cnt[k] - d[k]);
            end
        end
    endtask

    task automatic test_wrap_clamp();
        test_copy("wrap4", 16'd4, 100, 1'b0);
        test_copy("clamp48", 16'h0030, 80, 1'b0);
    endtask

    task automatic test_abort();
        int b[2];
        int d[2];
        int t;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        ack_pct = 100;
        for (int k = 0; k < 2; k++) begin
            b[k] = wcnt[k];
            d[k] = done_cnt[k];
            ack_limit[k] = wcnt[k] + 2;
        end
        @(negedge clk) downloading = 1'b1;
        repeat (6) @(negedge clk);
        size = 16'd10;
        downloading = 1'b0;
        t = 0;
        while (!(wcnt[0] - b[0] >= 2 && tgt_req[0] && wcnt[1] - b[1] >= 2 && tgt_req[1]) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 2000) begin
            n_bad++;
            $display("FAIL abort pending_timeout: waited %0d cycles for byte 3 request", t);
        end
        downloading = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (tgt_req !== 2'b00 || busy !== 2'b11) begin
            n_bad++;
            $display("FAIL abort req_drop: got req=%b busy=%b expected 00/11", tgt_req, busy);
        end
        repeat (10) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (wcnt[k] - b[k] != 2 || done_cnt[k] != d[k]) begin
                n_bad++;
                $display("FAIL abort u%0d: writes=%0d dones=%0d expected 2/0",
                         k, wcnt[k] - b[k], done_cnt[k] - d[k]);
            end
            ack_limit[k] = 32'h7fffffff;
        end
        test_copy("abort_next", 16'd5, 100, 1'b0);
    endtask

    task automatic test_reset_mid();
        int b[2];
        int t;
        ack_pct = 100;
        for (int k = 0; k < 2; k++) begin
            b[k] = wcnt[k];
            ack_limit[k] = wcnt[k] + 1;
        end
        @(negedge clk) downloading = 1'b1;
        repeat (6) @(negedge clk);
        size = 16'd10;
        downloading = 1'b0;
        t = 0;
        while (!(wcnt[0] - b[0] >= 1 && tgt_req[0] && wcnt[1] - b[1] >= 1 && tgt_req[1]) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 2000) begin
            n_bad++;
            $display("FAIL reset_mid pending_timeout: waited %0d cycles", t);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({tgt_req, busy, done} !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_mid async_clear: got req=%b busy=%b done=%b expected 00/00/00",
                     tgt_req, busy, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) ack_limit[k] = 32'h7fffffff;
        repeat (2) @(negedge clk);
        test_copy("after_reset", 16'd2, 100, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            test_copy("random", 16'($urandom_range(60, 1)), int'($urandom_range(100, 30)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_wrap_clamp();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
